seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Reads a multiplexed, active-low common-anode 7-segment display bus and
//  recovers the hex digit (0-F) shown on each position; inverse of our
//  hex->7seg encoder. Used as a display snooper / self-check monitor behind
//  the display driver. Stable per-digit codes are assembled into a full frame
//  and handed off on a valid/ready interface.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digit positions (>=1)
//  STABLE_CYCLES  3  consecutive identical samples required before capture (>=1)
// PORTS
//  clk          in   1             single clock; all logic on rising edge
//  rst          in   1             asynchronous, active-high reset
//  seg_n        in   7             segments, active low; [6]=a,[5]=b..[0]=g
//  an_n         in   NUM_DIGITS    digit enables, active low; bit i = digit i
//  frame_ready  in   1             consumer accepts frame_data
//  frame_data   out  4*NUM_DIGITS  digit i at [4i+3:4i]
//  frame_valid  out  1             frame_data holds an unaccepted frame
//  digit_stb    out  1             1-cycle pulse: digit captured
//  digit_idx    out  $clog2(NUM_DIGITS) (min 1)  index of captured digit
//  digit_val    out  4             decoded value of captured digit
//  bad_pattern  out  1             1-cycle pulse: stable pattern not in table
//  overrun      out  1             1-cycle pulse: completed frame dropped
// BEHAVIOUR
//  Reset: every output 0; input regs preset seg_n=7'h7F, an_n=all-ones
//   (blank); capture mask, stability counter, assembly buffer cleared; FSM=WAIT.
//  Input stage: seg_n/an_n registered once (sample S). No synchronisers; the
//   bus is same-clock.
//  Decode table (seg_n -> value), exact match only:
//   0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5 0100000=6
//   0001111=7 0000000=8 0000100=9 0000010=A 1100000=B 0110001=C 1000010=D
//   0110000=E 0111000=F; any other code is a bad pattern.
//  Stability FSM (on S={an,seg}):
//   WAIT : an not exactly one low bit, or S!=S_prev -> stay WAIT, cnt=0;
//          one-hot-low an and S==S_prev -> COUNT, cnt=1.
//   COUNT: S!=S_prev or an invalid -> WAIT; cnt++; when cnt==STABLE_CYCLES
//          -> CAPTURE action, go LOCKED.
//   LOCKED: hold while S==S_prev; any change -> WAIT. Exactly one capture
//          per stable episode. STABLE_CYCLES=1: capture on first repeat.
//  Latency: pins constant from edge k -> digit_stb/bad_pattern high during
//   cycle following edge k+STABLE_CYCLES+1.
//  Capture: valid code -> digit_stb=1, digit_idx/val driven same cycle,
//   buffer slot written, mask bit set. Invalid code -> bad_pattern=1,
//   buffer and mask untouched. Re-capture of a masked digit overwrites slot.
//  Frame: when mask becomes all ones, buffer -> frame_data, frame_valid=1,
//   mask cleared same edge. frame_data stable while frame_valid=1.
//  Handshake: frame_valid&frame_ready at edge -> frame_valid=0 next cycle.
//   Frame completes while frame_valid=1 and not accepted that edge -> new
//   frame dropped, overrun pulse, mask still cleared. Completion coincident
//   with acceptance -> new frame loaded, frame_valid stays 1, no overrun.
//  Reset mid-operation: immediate return to reset state; partial frame lost.
// TESTING
//  T1 rst, then an_n=1110 seg_n=0000110 held 5 cyc -> one digit_stb,
//     idx=0 val=3, 4 cycles after pins applied; no further pulses.
//  T2 scan digits 0..3 with 2,A,C,F, 4 cyc each, frame_ready=0 ->
//     frame_valid=1, frame_data=16'hFCA2; raise ready -> valid drops next cyc.
//  T3 seg_n=1111111 on digit 1 held -> bad_pattern pulse once; frame never
//     completes with digit 1 missing.
//  T4 pattern toggled every 2 cyc (< STABLE_CYCLES) -> no digit_stb.
//  T5 two full frames, ready=0 -> first frame kept, overrun pulses once;
//     repeat with ready=1 on completion edge -> no overrun, second loaded.
//  T6 rst asserted mid-frame -> all outputs 0 asynchronously; after release
//     first frame needs all NUM_DIGITS fresh captures.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundle of display-bus pins and frame handshake seen by the 7-segment scan decoder.
// The master drives the display pins and frame_ready; the slave is the decoder.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] frame_data;
  logic                    frame_valid;
  logic                    digit_stb;
  logic [IdxW-1:0]         digit_idx;
  logic [3:0]              digit_val;
  logic                    bad_pattern;
  logic                    overrun;

  modport master (
    output seg_n, an_n, frame_ready,
    input  frame_data, frame_valid, digit_stb, digit_idx, digit_val, bad_pattern, overrun
  );

  modport slave (
    input  seg_n, an_n, frame_ready,
    output frame_data, frame_valid, digit_stb, digit_idx, digit_val, bad_pattern, overrun
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, recovers each stable hex digit
// and assembles complete frames for a valid/ready consumer.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus_io
);
  localparam int IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CntW   = $clog2(STABLE_CYCLES + 1);
  localparam int FrameW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {StWait, StCount, StLocked} state_e;

  state_e                state_q, state_d;
  logic [6:0]            seg_q, segPrev_q;
  logic [NUM_DIGITS-1:0] an_q, anPrev_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [FrameW-1:0]     buf_q, buf_d, frameData_q, frameData_d;
  logic                  frameValid_q, frameValid_d;
  logic                  digitStb_q, digitStb_d;
  logic                  badPattern_q, badPattern_d;
  logic                  overrun_q, overrun_d;
  logic [IdxW-1:0]       digitIdx_q, digitIdx_d;
  logic [3:0]            digitVal_q, digitVal_d;

  logic                  same, anValid, capture, codeValid;
  logic [3:0]            codeVal;
  logic [IdxW-1:0]       anIdx;

  // Inverse of the hex->7seg encoder; returns {valid, value}, exact match only.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0000010: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  assign {codeValid, codeVal} = decodeSeg(seg_q);
  assign same    = (an_q == anPrev_q) && (seg_q == segPrev_q);
  assign anValid = $onehot(~an_q);

  always_comb begin
    anIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) anIdx = IdxW'(i);
    end
  end

  // Stability FSM: one capture per episode of identical, single-digit samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StWait: begin
        if (same && anValid) begin
          cnt_d = CntW'(1);
          if (STABLE_CYCLES == 1) begin
            capture = 1'b1;
            state_d = StLocked;
          end else begin
            state_d = StCount;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StCount: begin
        if (!same || !anValid) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (!same) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    buf_d        = buf_q;
    mask_d       = mask_q;
    frameData_d  = frameData_q;
    frameValid_d = frameValid_q;
    digitStb_d   = 1'b0;
    badPattern_d = 1'b0;
    overrun_d    = 1'b0;
    digitIdx_d   = digitIdx_q;
    digitVal_d   = digitVal_q;
    if (frameValid_q && bus_io.frame_ready) frameValid_d = 1'b0;
    if (capture) begin
      if (codeValid) begin
        digitStb_d = 1'b1;
        digitIdx_d = anIdx;
        digitVal_d = codeVal;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IdxW'(i) == anIdx) begin
            buf_d[4*i +: 4] = codeVal;
            mask_d[i]       = 1'b1;
          end
        end
        // A completed frame replaces the held one only if that one is gone or leaving now.
        if (&mask_d) begin
          mask_d = '0;
          if (!frameValid_q || bus_io.frame_ready) begin
            frameData_d  = buf_d;
            frameValid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end else begin
        badPattern_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StWait;
      seg_q        <= 7'h7F;
      segPrev_q    <= 7'h7F;
      an_q         <= '1;
      anPrev_q     <= '1;
      cnt_q        <= '0;
      mask_q       <= '0;
      buf_q        <= '0;
      frameData_q  <= '0;
      frameValid_q <= 1'b0;
      digitStb_q   <= 1'b0;
      badPattern_q <= 1'b0;
      overrun_q    <= 1'b0;
      digitIdx_q   <= '0;
      digitVal_q   <= '0;
    end else begin
      state_q      <= state_d;
      seg_q        <= bus_io.seg_n;
      segPrev_q    <= seg_q;
      an_q         <= bus_io.an_n;
      anPrev_q     <= an_q;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      buf_q        <= buf_d;
      frameData_q  <= frameData_d;
      frameValid_q <= frameValid_d;
      digitStb_q   <= digitStb_d;
      badPattern_q <= badPattern_d;
      overrun_q    <= overrun_d;
      digitIdx_q   <= digitIdx_d;
      digitVal_q   <= digitVal_d;
    end
  end

  assign bus_io.frame_data  = frameData_q;
  assign bus_io.frame_valid = frameValid_q;
  assign bus_io.digit_stb   = digitStb_q;
  assign bus_io.digit_idx   = digitIdx_q;
  assign bus_io.digit_val   = digitVal_q;
  assign bus_io.bad_pattern = badPattern_q;
  assign bus_io.overrun     = overrun_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a sample-history reference model queues
// expected captures, overruns and frame hand-offs; a negedge monitor checks them.
module tb_seg7_scan_decoder;
  localparam int NumDigits    = 4;
  localparam int StableCycles = 3;

  typedef struct {
    int cyc;
    bit bad;
    int idx;
    int val;
  } capEv_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } frameEv_t;

  logic clk;
  logic rst = 1'b1;
  int   edgeCnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  seg7_scan_if #(.NUM_DIGITS(NumDigits)) busIf ();

  seg7_scan_decoder #(
    .NUM_DIGITS   (NumDigits),
    .STABLE_CYCLES(StableCycles)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(busIf)
  );

  capEv_t   capQ[$];
  frameEv_t frameQ[$];
  int       ovrQ[$];

  // Reference model state: history of sampled pins plus frame bookkeeping.
  logic [6:0]  segCode [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [3:0]  mLastAn;
  logic [6:0]  mLastSeg;
  int          mRun;
  logic [3:0]  mBuf [NumDigits];
  bit          mGot [NumDigits];
  bit          mPending;
  logic [15:0] mHeld;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: run did not finish, edge %0d required below 40000", edgeCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  task automatic modelReset();
    mLastAn  = '1;
    mLastSeg = 7'h7F;
    mRun     = 1;
    mPending = 0;
    mHeld    = '0;
    for (int i = 0; i < NumDigits; i++) begin
      mBuf[i] = '0;
      mGot[i] = 0;
    end
  endtask

  // A digit is captured once, STABLE_CYCLES+1 identical single-digit samples into an episode.
  task automatic modelEdge(input int e, input logic rdy, input logic [3:0] an, input logic [6:0] seg);
    capEv_t   ce;
    frameEv_t fe;
    int       code;
    int       pos;
    bit       complete;
    bit       accept;
    complete = 0;
    code     = -1;
    pos      = -1;
    if (mRun == StableCycles + 1 && $countones(~mLastAn) == 1) begin
      for (int v = 0; v < 16; v++) if (segCode[v] == mLastSeg) code = v;
      for (int i = 0; i < NumDigits; i++) if (!mLastAn[i]) pos = i;
      ce.cyc = e;
      ce.bad = (code < 0);
      ce.idx = pos;
      ce.val = (code < 0) ? 0 : code;
      capQ.push_back(ce);
      if (code >= 0) begin
        mBuf[pos] = 4'(code);
        mGot[pos] = 1;
        complete  = 1;
        for (int i = 0; i < NumDigits; i++) if (!mGot[i]) complete = 0;
        if (complete) for (int i = 0; i < NumDigits; i++) mGot[i] = 0;
      end
    end
    accept = mPending && rdy;
    if (accept) begin
      fe.cyc  = e;
      fe.data = mHeld;
      frameQ.push_back(fe);
    end
    if (complete) begin
      if (mPending && !accept) begin
        ovrQ.push_back(e);
      end else begin
        for (int i = 0; i < NumDigits; i++) mHeld[4*i +: 4] = mBuf[i];
        mPending = 1;
      end
    end else if (accept) begin
      mPending = 0;
    end
    if (an == mLastAn && seg == mLastSeg) begin
      if (mRun < 1000) mRun++;
    end else begin
      mRun     = 1;
      mLastAn  = an;
      mLastSeg = seg;
    end
  endtask

  // readyMode: 0 low, 1 high, 2 random per cycle, 3 high only on the completion edge.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int hold, input int readyMode);
    logic r;
    for (int j = 0; j < hold; j++) begin
      case (readyMode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        3:       r = (j == StableCycles + 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      busIf.an_n        = an;
      busIf.seg_n       = seg;
      busIf.frame_ready = r;
      modelEdge(edgeCnt + 1, r, an, seg);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState();
    checkOutput("reset frame_valid", 32'(busIf.frame_valid), 0);
    checkOutput("reset frame_data", 32'(busIf.frame_data), 0);
    checkOutput("reset digit_stb", 32'(busIf.digit_stb), 0);
    checkOutput("reset digit_idx", 32'(busIf.digit_idx), 0);
    checkOutput("reset digit_val", 32'(busIf.digit_val), 0);
    checkOutput("reset bad_pattern", 32'(busIf.bad_pattern), 0);
    checkOutput("reset overrun", 32'(busIf.overrun), 0);
  endtask

  task automatic resetMid();
    busIf.frame_ready = 1'b0;
    @(negedge clk);
    #1;
    capQ.delete();
    frameQ.delete();
    ovrQ.delete();
    rst = 1'b1;
    #1;
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic scanFrame(input int v0, input int v1, input int v2, input int v3, input int hold,
                           input int readyLast);
    applyStimulus(4'b1110, segCode[v0], hold, 0);
    applyStimulus(4'b1101, segCode[v1], hold, 0);
    applyStimulus(4'b1011, segCode[v2], hold, 0);
    applyStimulus(4'b0111, segCode[v3], hold, readyLast);
  endtask

  // Monitor: every DUT pulse or hand-off must match the head of its queue at the right edge.
  always @(negedge clk) begin
    capEv_t   ce;
    frameEv_t fe;
    int       oc;
    if (busIf.digit_stb || busIf.bad_pattern) begin
      if (capQ.size() == 0) begin
        checkOutput("spurious digit_stb", 32'(busIf.digit_stb), 0);
        checkOutput("spurious bad_pattern", 32'(busIf.bad_pattern), 0);
      end else begin
        ce = capQ.pop_front();
        checkOutput("capture edge", edgeCnt, ce.cyc);
        checkOutput("bad_pattern", 32'(busIf.bad_pattern), 32'(ce.bad));
        checkOutput("digit_stb", 32'(busIf.digit_stb), 32'(!ce.bad));
        if (!ce.bad) begin
          checkOutput("digit_idx", 32'(busIf.digit_idx), ce.idx);
          checkOutput("digit_val", 32'(busIf.digit_val), ce.val);
        end
      end
    end else if (capQ.size() > 0 && capQ[0].cyc <= edgeCnt) begin
      ce = capQ.pop_front();
      checkOutput("missing capture pulse", 32'(busIf.digit_stb | busIf.bad_pattern), 1);
    end

    if (busIf.overrun) begin
      if (ovrQ.size() == 0) begin
        checkOutput("spurious overrun", 32'(busIf.overrun), 0);
      end else begin
        oc = ovrQ.pop_front();
        checkOutput("overrun edge", edgeCnt, oc);
      end
    end else if (ovrQ.size() > 0 && ovrQ[0] <= edgeCnt) begin
      oc = ovrQ.pop_front();
      checkOutput("missing overrun", 32'(busIf.overrun), 1);
    end

    if (busIf.frame_valid && busIf.frame_ready) begin
      if (frameQ.size() == 0) begin
        checkOutput("spurious frame_valid", 32'(busIf.frame_valid), 0);
      end else begin
        fe = frameQ.pop_front();
        checkOutput("frame accept edge", edgeCnt + 1, fe.cyc);
        checkOutput("frame_data", 32'(busIf.frame_data), 32'(fe.data));
      end
    end else if (frameQ.size() > 0 && frameQ[0].cyc <= edgeCnt + 1) begin
      fe = frameQ.pop_front();
      checkOutput("missing frame_valid", 32'(busIf.frame_valid), 1);
    end
  end

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    busIf.an_n        = '1;
    busIf.seg_n       = 7'h7F;
    busIf.frame_ready = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b0;
    modelReset();

    // Single stable digit, then blank.
    applyStimulus(4'b1110, 7'b0000110, 5, 0);
    applyStimulus(4'b1111, 7'h7F, 3, 0);

    // Full scan 2,A,C,F held while ready is low, then accepted.
    scanFrame(2, 10, 12, 15, 4, 0);
    applyStimulus(4'b1111, 7'h7F, 4, 0);
    applyStimulus(4'b1111, 7'h7F, 3, 1);

    // Blank pattern on digit 1: bad pattern, frame cannot complete.
    applyStimulus(4'b1101, 7'b1111111, 6, 1);
    applyStimulus(4'b1110, segCode[5], 5, 1);
    applyStimulus(4'b1011, segCode[6], 5, 1);
    applyStimulus(4'b0111, segCode[7], 5, 1);

    // Patterns toggling faster than the stability window.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1101, segCode[1], 2, 1);
      applyStimulus(4'b1101, segCode[8], 2, 1);
    end
    applyStimulus(4'b1111, 7'h7F, 3, 1);

    // Overrun, then completion coinciding with acceptance.
    scanFrame(1, 2, 3, 4, 5, 0);
    scanFrame(5, 6, 7, 8, 5, 0);
    scanFrame(9, 11, 13, 14, 5, 0);
    applyStimulus(4'b0111, segCode[0], StableCycles + 3, 3);
    applyStimulus(4'b1111, 7'h7F, 2, 0);
    scanFrame(3, 1, 4, 1, 6, 0);
    scanFrame(5, 9, 2, 6, 4, 3);
    applyStimulus(4'b1111, 7'h7F, 4, 1);

    // Reset with a partial frame pending, then a fresh frame.
    applyStimulus(4'b1110, segCode[12], 5, 1);
    applyStimulus(4'b1101, segCode[13], 5, 1);
    resetMid();
    applyStimulus(4'b1011, segCode[4], 5, 1);
    applyStimulus(4'b0111, segCode[9], 5, 1);
    scanFrame(15, 14, 13, 12, 5, 1);
    applyStimulus(4'b1111, 7'h7F, 3, 1);

    // Randomised episodes.
    for (int n = 0; n < 350; n++) begin
      if ($urandom_range(0, 9) < 8) an = ~(4'b0001 << $urandom_range(0, 3));
      else an = 4'($urandom);
      if ($urandom_range(0, 9) < 8) seg = segCode[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      applyStimulus(an, seg, $urandom_range(1, 7), $urandom_range(0, 3));
      if (n == 200) resetMid();
    end

    applyStimulus(4'b1111, 7'h7F, 12, 1);
    @(negedge clk);
    #1;
    checkOutput("capture queue drained", capQ.size(), 0);
    checkOutput("frame queue drained", frameQ.size(), 0);
    checkOutput("overrun queue drained", ovrQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
